// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  // RV32I funct3 width/sign codes (loads and stores share encodings 0..2)
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WAIT  = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane steering: load extract+extend and store merge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
// Ports: funct3/offset select the lane; rdata_word is the memory word,
// store_wdata the store source; load_data is the extended result and
// store_data the memory word with the target lane replaced.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata_word,
  input  logic [31:0] store_wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata_word[31:16] : rdata_word[15:0];

    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = rdata_word;
    endcase

    store_data = rdata_word;
    case (funct3)
      SB: store_data[{offset, 3'b000} +: 8] = store_wdata[7:0];
      SH: begin
        if (offset[1]) store_data[31:16] = store_wdata[15:0];
        else           store_data[15:0]  = store_wdata[15:0];
      end
      default: store_data = store_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I byte-addressed load/store to word-addressed memory without byte enables.
// Latency: SW and errors 1 cycle; loads and SB/SH 2 cycles (read, then result/write).
// Backpressure: stall_o holds the core during the first cycle of a 2-cycle access.
// Ports: req_* is the core request, stall_o/rdata_o/rdata_valid_o/err_o go back
// to the core, mem_* drive the data memory whose read data returns one cycle later.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_read_i
);

  lsu_state_t            state;
  logic [2:0]            lat_funct3;
  logic [1:0]            lat_offset;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;

  logic [ADDR_WIDTH-1:0] req_word_addr;
  logic [1:0]            req_offset;
  logic                  req_err;
  logic                  req_sw;
  logic [31:0]           load_data;
  logic [31:0]           store_data;

  // Address bits above the memory's word range are dropped on purpose (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[31:ADDR_WIDTH+2];

  assign req_word_addr = req_addr_i[ADDR_WIDTH+1:2];
  assign req_offset    = req_addr_i[1:0];
  assign req_sw        = req_we_i && (req_funct3_i == SW);

  always_comb begin
    req_err = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        SB:      req_err = 1'b0;
        SH:      req_err = req_offset[0];
        SW:      req_err = (req_offset != 2'd0);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        LB, LBU: req_err = 1'b0;
        LH, LHU: req_err = req_offset[0];
        LW:      req_err = (req_offset != 2'd0);
        default: req_err = 1'b1;
      endcase
    end
  end

  lsu_align u_align (
    .funct3      (lat_funct3),
    .offset      (lat_offset),
    .rdata_word  (mem_data_read_i),
    .store_wdata (lat_wdata),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Outputs are gated by rst_n so nothing reaches memory or core while reset
  // is held, even if a request is presented in IDLE.
  always_comb begin
    stall_o          = 1'b0;
    rdata_o          = '0;
    rdata_valid_o    = 1'b0;
    err_o            = 1'b0;
    mem_address_o    = '0;
    mem_write_data_o = '0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (req_err) begin
              err_o = 1'b1;
            end else if (req_sw) begin
              mem_write_o      = 1'b1;
              mem_address_o    = req_word_addr;
              mem_write_data_o = req_wdata_i;
            end else begin
              // loads and sub-word stores both start with a read
              mem_read_o    = 1'b1;
              stall_o       = 1'b1;
              mem_address_o = req_word_addr;
            end
          end
        end
        LOAD_WAIT: begin
          rdata_valid_o = 1'b1;
          rdata_o       = load_data;
          mem_address_o = lat_addr;
        end
        RMW_WAIT: begin
          mem_write_o      = 1'b1;
          mem_address_o    = lat_addr;
          mem_write_data_o = store_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_funct3 <= '0;
      lat_offset <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && !req_err && !req_sw) begin
            lat_funct3 <= req_funct3_i;
            lat_offset <= req_offset;
            lat_addr   <= req_word_addr;
            lat_wdata  <= req_wdata_i;
            state      <= req_we_i ? RMW_WAIT : LOAD_WAIT;
          end
        end
        LOAD_WAIT: state <= IDLE;
        RMW_WAIT:  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
